// File: rtl/cache_controller_pkg.sv
// Shared definitions for the 2-way write-through data cache: address field
// positions, FSM state encoding and the victim-selection helper.
package cache_controller_pkg;

    localparam int SETS       = 64;
    localparam int INDEX_W    = 6;
    localparam int TAG_W      = 10;
    localparam int WORD_W     = 32;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 3;
    localparam int TAG_LSB    = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL0 = 3'd1,
        FILL1 = 3'd2,
        RESP  = 3'd3,
        WRITE = 3'd4
    } state_e;

    // An empty way always beats the LRU choice; way0 first when both are empty.
    function automatic logic pick_victim(input logic valid0, input logic valid1, input logic lru);
        if (!valid0) begin
            return 1'b0;
        end else if (!valid1) begin
            return 1'b1;
        end else begin
            return lru;
        end
    endfunction

endpackage

// File: rtl/cache_controller_memory_array.sv
// Tag/data/valid/lru storage for the 2-way cache with combinational lookup
// and synchronous fill, word-update and lru-touch ports.
module cache_memory_array
    import cache_controller_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               offset_i,
    output logic               hit_o,
    output logic               hit_way_o,
    output logic [WORD_W-1:0]  hit_word_o,
    output logic               victim_way_o,
    input  logic               fill_en_i,
    input  logic               fill_way_i,
    input  logic [WORD_W-1:0]  fill_word0_i,
    input  logic [WORD_W-1:0]  fill_word1_i,
    input  logic               upd_en_i,
    input  logic               upd_way_i,
    input  logic [WORD_W-1:0]  upd_word_i,
    input  logic               touch_en_i,
    input  logic               touch_way_i
);

    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [WORD_W-1:0] data_q  [2][SETS][2];

    logic hit0_s;
    logic hit1_s;
    logic hit_way_s;

    // Tag compare in both ways; a double hit resolves to way0.
    always_comb begin
        hit0_s    = valid_q[0][index_i] && (tag_q[0][index_i] == tag_i);
        hit1_s    = valid_q[1][index_i] && (tag_q[1][index_i] == tag_i);
        hit_way_s = 1'b0;
        if (hit0_s) begin
            hit_way_s = 1'b0;
        end else if (hit1_s) begin
            hit_way_s = 1'b1;
        end else begin
            hit_way_s = 1'b0;
        end
    end

    assign hit_o        = hit0_s | hit1_s;
    assign hit_way_o    = hit_way_s;
    assign hit_word_o   = data_q[hit_way_s][index_i][offset_i];
    assign victim_way_o = pick_victim(valid_q[0][index_i], valid_q[1][index_i], lru_q[index_i]);

    // Valid and lru bits: cleared by reset, set by fills and accesses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (fill_en_i) begin
                valid_q[fill_way_i][index_i] <= 1'b1;
            end
            if (touch_en_i) begin
                lru_q[index_i] <= ~touch_way_i;
            end
        end
    end

    // Tag and data storage; contents are only meaningful behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[fill_way_i][index_i]        <= tag_i;
            data_q[fill_way_i][index_i][1'b0] <= fill_word0_i;
            data_q[fill_way_i][index_i][1'b1] <= fill_word1_i;
        end else if (upd_en_i) begin
            data_q[upd_way_i][index_i][offset_i] <= upd_word_i;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate data cache.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_write,
    output logic        sram_read,
    input  logic        sram_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    state_e state_q, state_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;

    logic [INDEX_W-1:0] index_s;
    logic [TAG_W-1:0]   tag_s;
    logic               offset_s;
    logic               hit_s;
    logic               hit_way_s;
    logic [31:0]        hit_word_s;
    logic               victim_way_s;

    logic        ready_s;
    logic [31:0] rdata_s;
    logic        sram_read_s;
    logic        sram_write_s;
    logic [31:0] sram_address_s;
    logic [31:0] sram_wdata_s;
    logic        fill_en_s;
    logic        upd_en_s;
    logic        touch_en_s;
    logic        touch_way_s;
    logic        hit_acc_s;
    logic        miss_acc_s;

    assign index_s  = address[INDEX_LSB +: INDEX_W];
    assign tag_s    = address[TAG_LSB +: TAG_W];
    assign offset_s = address[OFFSET_LSB];

    cache_memory_array u_array (
        .clk_i        (clk),
        .rst_i        (rst),
        .index_i      (index_s),
        .tag_i        (tag_s),
        .offset_i     (offset_s),
        .hit_o        (hit_s),
        .hit_way_o    (hit_way_s),
        .hit_word_o   (hit_word_s),
        .victim_way_o (victim_way_s),
        .fill_en_i    (fill_en_s),
        .fill_way_i   (victim_way_s),
        .fill_word0_i (word0_q),
        .fill_word1_i (sram_rdata),
        .upd_en_i     (upd_en_s),
        .upd_way_i    (hit_way_s),
        .upd_word_i   (wdata),
        .touch_en_i   (touch_en_s),
        .touch_way_i  (touch_way_s)
    );

    // State and fill-word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word0_q <= 32'd0;
            word1_q <= 32'd0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
        end
    end

    // Next-state, pipeline handshake and SRAM request decode; reset forces the idle view.
    always_comb begin
        state_d        = state_q;
        word0_d        = word0_q;
        word1_d        = word1_q;
        ready_s        = 1'b0;
        rdata_s        = 32'd0;
        sram_read_s    = 1'b0;
        sram_write_s   = 1'b0;
        sram_address_s = 32'd0;
        sram_wdata_s   = 32'd0;
        fill_en_s      = 1'b0;
        upd_en_s       = 1'b0;
        touch_en_s     = 1'b0;
        touch_way_s    = 1'b0;
        hit_acc_s      = 1'b0;
        miss_acc_s     = 1'b0;
        if (rst) begin
            ready_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MEM_W_EN) begin
                        state_d = WRITE;
                        if (hit_s) begin
                            upd_en_s    = 1'b1;
                            touch_en_s  = 1'b1;
                            touch_way_s = hit_way_s;
                        end else begin
                            upd_en_s = 1'b0;
                        end
                    end else if (MEM_R_EN) begin
                        if (hit_s) begin
                            ready_s     = 1'b1;
                            rdata_s     = hit_word_s;
                            touch_en_s  = 1'b1;
                            touch_way_s = hit_way_s;
                            hit_acc_s   = 1'b1;
                        end else begin
                            state_d    = FILL0;
                            miss_acc_s = 1'b1;
                        end
                    end else begin
                        ready_s = 1'b1;
                    end
                end
                FILL0: begin
                    sram_read_s    = 1'b1;
                    sram_address_s = {address[31:3], 3'b000};
                    if (sram_ready) begin
                        word0_d = sram_rdata;
                        state_d = FILL1;
                    end else begin
                        state_d = FILL0;
                    end
                end
                FILL1: begin
                    sram_read_s    = 1'b1;
                    sram_address_s = {address[31:3], 3'b100};
                    if (sram_ready) begin
                        word1_d     = sram_rdata;
                        fill_en_s   = 1'b1;
                        touch_en_s  = 1'b1;
                        touch_way_s = victim_way_s;
                        state_d     = RESP;
                    end else begin
                        state_d = FILL1;
                    end
                end
                RESP: begin
                    ready_s = 1'b1;
                    rdata_s = offset_s ? word1_q : word0_q;
                    state_d = IDLE;
                end
                WRITE: begin
                    sram_write_s   = 1'b1;
                    sram_address_s = address;
                    sram_wdata_s   = wdata;
                    if (sram_ready) begin
                        ready_s = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WRITE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ready        = ready_s;
    assign rdata        = rdata_s;
    assign sram_read    = sram_read_s;
    assign sram_write   = sram_write_s;
    assign sram_address = sram_address_s;
    assign sram_wdata   = sram_wdata_s;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Wrapping hit/miss counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            if (hit_acc_s) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_acc_s) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = hit_acc_s ^ miss_acc_s;
    assign hit_count      = 32'd0;
    assign miss_count     = 32'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed scoreboard bench for cache_controller with a behavioural SRAM
// controller that checks every completed SRAM operation against a queue.
module tb_cache_controller;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_write;
    logic        sram_read;
    logic        sram_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } sram_op_t;

    sram_op_t    sq[$];
    logic [31:0] rdq[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          bad   = 0;
    int          cnt   = 0;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_write   (sram_write),
        .sram_read    (sram_read),
        .sram_ready   (sram_ready),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem.exists(a)) begin
            return mem[a];
        end else begin
            return {a[15:0], 16'hC0DE};
        end
    endfunction

    task automatic exp_sram(input logic wr, input logic [31:0] a, input logic [31:0] d);
        sram_op_t op;
        op.wr = wr;
        op.addr = a;
        op.data = d;
        sq.push_back(op);
    endtask

    task automatic exp_fill(input logic [31:0] a);
        exp_sram(1'b0, {a[31:3], 3'b000}, 32'd0);
        exp_sram(1'b0, {a[31:3], 3'b100}, 32'd0);
    endtask

    // SRAM controller model: two-cycle latency, one-cycle ready pulse.
    always @(negedge clk) begin
        if (rst) begin
            sram_ready = 1'b0;
            cnt = 0;
        end else if (sram_ready) begin
            sram_ready = 1'b0;
            cnt = 0;
        end else if (sram_read || sram_write) begin
            cnt++;
            if (cnt == 2) begin
                sram_ready = 1'b1;
                check("sram_op_queued", 32'(sq.size() > 0), 32'd1);
                if (sq.size() > 0) begin
                    sram_op_t op;
                    op = sq.pop_front();
                    check("sram_is_write", 32'(sram_write), 32'(op.wr));
                    check("sram_addr", sram_address, op.addr);
                    if (op.wr) begin
                        check("sram_wdata", sram_wdata, op.data);
                    end
                end
                if (sram_write) begin
                    mem[sram_address] = sram_wdata;
                end else begin
                    sram_rdata = mem_val(sram_address);
                end
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_hit);
        int   stall;
        logic done;
        logic [31:0] e;
        if (rd && !wr) rdq.push_back(exp_rd);
        @(posedge clk); #1;
        MEM_R_EN = rd;
        MEM_W_EN = wr;
        address  = addr;
        wdata    = data;
        stall = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #1;
            if (ready) done = 1'b1;
            else stall++;
        end
        check("ready_seen", 32'(done), 32'd1);
        if (rd && !wr && rdq.size() > 0) begin
            e = rdq.pop_front();
            check("rdata", rdata, e);
        end
        check("zero_stall", 32'(stall == 0), 32'(exp_hit));
        @(posedge clk); #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rdata", rdata, 32'd0);
    endtask

    initial begin
        logic found;
        rst = 1'b1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        address = 32'd0;
        wdata = 32'd0;
        sram_rdata = 32'd0;
        sram_ready = 1'b0;
        mem[32'h10] = 32'hAAAA_0000;
        mem[32'h14] = 32'hBBBB_0004;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_rdata", rdata, 32'd0);
        check("reset_sram_rw", {30'd0, sram_read, sram_write}, 32'd0);
        check("reset_sram_addr", sram_address, 32'd0);
        check("reset_sram_wdata", sram_wdata, 32'd0);
        check("reset_hits", hit_count, 32'd0);

        // Read miss then hit on the other word of the block
        exp_fill(32'h10);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 32'hAAAA_0000, 1'b0);
        do_req(1'b1, 1'b0, 32'h14, 32'd0, 32'hBBBB_0004, 1'b1);
        check("stats_hit", hit_count, STATS ? 32'd1 : 32'd0);
        check("stats_miss", miss_count, STATS ? 32'd1 : 32'd0);

        // Write hit goes through and updates the cached word
        exp_sram(1'b1, 32'h10, 32'h1234_5678);
        do_req(1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'd0, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 32'h1234_5678, 1'b1);
        do_req(1'b1, 1'b0, 32'h0008_0010, 32'd0, 32'h1234_5678, 1'b1);
        do_req(1'b1, 1'b0, 32'h14, 32'd0, 32'hBBBB_0004, 1'b1);

        // Both enables act as a write
        exp_sram(1'b1, 32'h14, 32'hCAFE_F00D);
        do_req(1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, 32'd0, 1'b0);
        do_req(1'b1, 1'b0, 32'h14, 32'd0, 32'hCAFE_F00D, 1'b1);

        // Write miss does not allocate
        exp_sram(1'b1, 32'h400, 32'hDEAD_BEEF);
        do_req(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 32'd0, 1'b0);
        exp_fill(32'h400);
        do_req(1'b1, 1'b0, 32'h400, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // LRU eviction in set 0 from a clean cache
        pulse_reset();
        exp_fill(32'h000);
        do_req(1'b1, 1'b0, 32'h000, 32'd0, mem_val(32'h000), 1'b0);
        exp_fill(32'h200);
        do_req(1'b1, 1'b0, 32'h200, 32'd0, mem_val(32'h200), 1'b0);
        do_req(1'b1, 1'b0, 32'h000, 32'd0, mem_val(32'h000), 1'b1);
        exp_fill(32'h400);
        do_req(1'b1, 1'b0, 32'h400, 32'd0, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b1, 1'b0, 32'h000, 32'd0, mem_val(32'h000), 1'b1);
        exp_fill(32'h200);
        do_req(1'b1, 1'b0, 32'h200, 32'd0, mem_val(32'h200), 1'b0);
        do_req(1'b1, 1'b0, 32'h204, 32'd0, mem_val(32'h204), 1'b1);

        // Reset during FILL1 aborts the fill
        exp_sram(1'b0, 32'h808, 32'd0);
        @(posedge clk); #1;
        MEM_R_EN = 1'b1;
        address  = 32'h808;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (sram_read && sram_address == 32'h80C) found = 1'b1;
        end
        check("fill1_reached", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_sram_read", 32'(sram_read), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        MEM_R_EN = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_fill(32'h808);
        do_req(1'b1, 1'b0, 32'h808, 32'd0, mem_val(32'h808), 1'b0);
        check("stats_hit_after_rst", hit_count, 32'd0);
        check("stats_miss_after_rst", miss_count, STATS ? 32'd1 : 32'd0);

        repeat (3) @(negedge clk);
        check("sram_queue_drained", 32'(sq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
